// File: rtl/btn_counter_bank_pkg.sv
// Shared types and cycle-count helpers for the push-button
// front end.
package btn_counter_bank_pkg;

  typedef enum logic [1:0] {
    ZERO,
    WAIT1,
    ONE,
    WAIT0
  } state_e;

  function automatic int cyc(real t, int freq);
    return $rtoi(t * real'(freq));
  endfunction

  function automatic int timer_w(int db_cyc, int hold_cyc);
    int m;
    m = (db_cyc > hold_cyc) ? db_cyc : hold_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: synchroniser, debounce FSM, hold/auto-repeat
// timer and wrap-around press counter.
module btn_channel
  import btn_counter_bank_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int DB_CYC   = 10,
  parameter int HOLD_CYC = 50,
  parameter int RPT_CYC  = 20,
  parameter int TW       = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn,
  input  logic             rpt_en,
  input  logic             clr,
  output logic             db,
  output logic             press_tick,
  output logic             release_tick,
  output logic             rpt_tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [TW-1:0] DB_LAST  = TW'(DB_CYC - 1);
  localparam logic [TW-1:0] HOLD_LST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] HOLD_RLD = TW'(HOLD_CYC - RPT_CYC);

  logic             s1_q, s_q;
  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [TW-1:0]    hold_q, hold_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign press_tick   = (state_q == WAIT1) && s_q
                      && (timer_q == DB_LAST);
  assign release_tick = (state_q == WAIT0) && !s_q
                      && (timer_q == DB_LAST);
  assign rpt_tick     = (state_q == ONE) && rpt_en
                      && (hold_q == HOLD_LST);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    db_d    = db_q;
    count_d = count_q;
    unique case (state_q)
      ZERO: begin
        if (s_q) begin
          state_d = WAIT1;
          timer_d = '0;
        end
      end
      WAIT1: begin
        if (!s_q) begin
          state_d = ZERO;
        end else if (timer_q == DB_LAST) begin
          state_d = ONE;
          db_d    = 1'b1;
          hold_d  = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ONE: begin
        // Hold timer only advances while held and enabled.
        if (rpt_en) begin
          hold_d = rpt_tick ? HOLD_RLD : hold_q + TW'(1);
        end
        if (!s_q) begin
          state_d = WAIT0;
          timer_d = '0;
        end
      end
      WAIT0: begin
        if (s_q) begin
          state_d = ONE;
        end else if (timer_q == DB_LAST) begin
          state_d = ZERO;
          db_d    = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ZERO;
    endcase
    if (clr) begin
      count_d = '0;
    end else if (press_tick || rpt_tick) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s_q     <= 1'b0;
      state_q <= ZERO;
      timer_q <= '0;
      hold_q  <= '0;
      db_q    <= 1'b0;
      count_q <= '0;
    end else begin
      s1_q    <= btn;
      s_q     <= s1_q;
      state_q <= state_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      db_q    <= db_d;
      count_q <= count_d;
    end
  end

  assign db    = db_q;
  assign count = count_q;

endmodule

// File: rtl/btn_counter_bank.sv
// Bank of independent debounced, auto-repeating button
// counters with packed outputs.
module btn_counter_bank
  import btn_counter_bank_pkg::*;
#(
  parameter int  N_BTN     = 4,
  parameter int  CNT_W     = 4,
  parameter int  CLK_FREQ  = 100_000_000,
  parameter real DB_TIME   = 0.100,
  parameter real HOLD_TIME = 0.500,
  parameter real RPT_TIME  = 0.100
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_BTN-1:0]       btn,
  input  logic                   rpt_en,
  input  logic                   clr,
  output logic [N_BTN-1:0]       db,
  output logic [N_BTN-1:0]       press_tick,
  output logic [N_BTN-1:0]       release_tick,
  output logic [N_BTN-1:0]       rpt_tick,
  output logic [N_BTN*CNT_W-1:0] count
);

  localparam int DB_CYC   = cyc(DB_TIME, CLK_FREQ);
  localparam int HOLD_CYC = cyc(HOLD_TIME, CLK_FREQ);
  localparam int RPT_CYC  = cyc(RPT_TIME, CLK_FREQ);
  localparam int TW       = timer_w(DB_CYC, HOLD_CYC);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .CNT_W   (CNT_W),
      .DB_CYC  (DB_CYC),
      .HOLD_CYC(HOLD_CYC),
      .RPT_CYC (RPT_CYC),
      .TW      (TW)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn         (btn[i]),
      .rpt_en      (rpt_en),
      .clr         (clr),
      .db          (db[i]),
      .press_tick  (press_tick[i]),
      .release_tick(release_tick[i]),
      .rpt_tick    (rpt_tick[i]),
      .count       (count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_btn_counter_bank.sv
// Directed bench for btn_counter_bank with DB=10,
// HOLD=50, RPT=20 cycles.
module tb_btn_counter_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  btn;
  logic        rpt_en;
  logic        clr;
  logic [3:0]  db, press_tick, release_tick, rpt_tick;
  logic [15:0] count;

  int tests = 0;
  int fails = 0;
  int press_n[4];
  int rel_n[4];
  int rpt_n[4];
  int tog_n[4];
  logic [3:0] db_prev;

  btn_counter_bank #(
    .N_BTN    (4),
    .CNT_W    (4),
    .CLK_FREQ (1000),
    .DB_TIME  (0.010),
    .HOLD_TIME(0.050),
    .RPT_TIME (0.020)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn         (btn),
    .rpt_en      (rpt_en),
    .clr         (clr),
    .db          (db),
    .press_tick  (press_tick),
    .release_tick(release_tick),
    .rpt_tick    (rpt_tick),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic clear_acc();
    for (int i = 0; i < 4; i++) begin
      press_n[i] = 0;
      rel_n[i]   = 0;
      rpt_n[i]   = 0;
      tog_n[i]   = 0;
    end
    db_prev = db;
  endtask

  // Advance n edges; sample 1 time unit after each edge.
  task automatic step(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        press_n[i] += int'(press_tick[i]);
        rel_n[i]   += int'(release_tick[i]);
        rpt_n[i]   += int'(rpt_tick[i]);
        if (db[i] !== db_prev[i]) tog_n[i]++;
      end
      db_prev = db;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(2);
    tests++;
    if ({db, count} !== 20'h0) begin
      fails++;
      $display("FAIL reset_out got %h exp 0", {db, count});
    end
    tests++;
    if ({press_tick, release_tick, rpt_tick} !== 12'h0) begin
      fails++;
      $display("FAIL reset_ticks got %h exp 0",
               {press_tick, release_tick, rpt_tick});
    end
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_clean_press();
    clear_acc();
    btn[0] = 1'b1;
    step(12);
    tests++;
    if (db[0] !== 1'b0) begin
      fails++;
      $display("FAIL press_db_early got %b exp 0", db[0]);
    end
    step(1);
    tests++;
    if (db[0] !== 1'b1 || count[3:0] !== 4'd1) begin
      fails++;
      $display("FAIL press_db_edge got db=%b cnt=%0d exp 1 1",
               db[0], count[3:0]);
    end
    step(17);
    btn[0] = 1'b0;
    step(12);
    tests++;
    if (db[0] !== 1'b1) begin
      fails++;
      $display("FAIL release_db_early got %b exp 1", db[0]);
    end
    step(1);
    tests++;
    if (db[0] !== 1'b0 || press_n[0] != 1 || rel_n[0] != 1) begin
      fails++;
      $display("FAIL clean_press got db=%b p=%0d r=%0d exp 0 1 1",
               db[0], press_n[0], rel_n[0]);
    end
  endtask

  task automatic test_bounce();
    clear_acc();
    for (int p = 0; p < 4; p++) begin
      btn[1] = 1'b1;
      step(5);
      btn[1] = 1'b0;
      step(5);
    end
    tests++;
    if (tog_n[1] != 0 || press_n[1] != 0) begin
      fails++;
      $display("FAIL bounce_quiet got tog=%0d p=%0d exp 0 0",
               tog_n[1], press_n[1]);
    end
    btn[1] = 1'b1;
    step(20);
    tests++;
    if (db[1] !== 1'b1 || count[7:4] !== 4'd1
        || press_n[1] != 1 || tog_n[1] != 1) begin
      fails++;
      $display("FAIL bounce_press got db=%b c=%0d p=%0d t=%0d exp 1 1 1 1",
               db[1], count[7:4], press_n[1], tog_n[1]);
    end
    btn[1] = 1'b0;
    step(13);
  endtask

  task automatic test_repeat();
    clear_acc();
    rpt_en = 1'b1;
    btn[2] = 1'b1;
    step(13);
    step(49);
    tests++;
    if (count[11:8] !== 4'd1) begin
      fails++;
      $display("FAIL rpt_before got %0d exp 1", count[11:8]);
    end
    step(1);
    tests++;
    if (count[11:8] !== 4'd2) begin
      fails++;
      $display("FAIL rpt_first got %0d exp 2", count[11:8]);
    end
    step(19);
    tests++;
    if (count[11:8] !== 4'd2) begin
      fails++;
      $display("FAIL rpt_gap got %0d exp 2", count[11:8]);
    end
    step(1);
    tests++;
    if (count[11:8] !== 4'd3) begin
      fails++;
      $display("FAIL rpt_second got %0d exp 3", count[11:8]);
    end
    step(50);
    btn[2] = 1'b0;
    step(13);
    tests++;
    if (count[11:8] !== 4'd5 || rpt_n[2] != 4 || db[2] !== 1'b0) begin
      fails++;
      $display("FAIL rpt_total got c=%0d r=%0d db=%b exp 5 4 0",
               count[11:8], rpt_n[2], db[2]);
    end
    rpt_en = 1'b0;
  endtask

  task automatic test_no_repeat();
    pulse_clr();
    clear_acc();
    rpt_en = 1'b0;
    btn[2] = 1'b1;
    step(133);
    btn[2] = 1'b0;
    step(13);
    tests++;
    if (count[11:8] !== 4'd1 || rpt_n[2] != 0) begin
      fails++;
      $display("FAIL no_rpt got c=%0d r=%0d exp 1 0",
               count[11:8], rpt_n[2]);
    end
  endtask

  task automatic test_wrap_clr();
    clear_acc();
    for (int p = 0; p < 17; p++) begin
      btn[3] = 1'b1;
      step(13);
      btn[3] = 1'b0;
      step(13);
    end
    tests++;
    if (count[15:12] !== 4'd1 || press_n[3] != 17) begin
      fails++;
      $display("FAIL wrap got c=%0d p=%0d exp 1 17",
               count[15:12], press_n[3]);
    end
    btn[3] = 1'b1;
    step(12);
    tests++;
    if (press_tick[3] !== 1'b1) begin
      fails++;
      $display("FAIL clr_tick_setup got %b exp 1", press_tick[3]);
    end
    pulse_clr();
    tests++;
    if (count[15:12] !== 4'd0 || db[3] !== 1'b1) begin
      fails++;
      $display("FAIL clr_priority got c=%0d db=%b exp 0 1",
               count[15:12], db[3]);
    end
    btn[3] = 1'b0;
    step(13);
  endtask

  task automatic test_simultaneous();
    pulse_clr();
    clear_acc();
    btn = 4'hF;
    step(12);
    tests++;
    if (press_tick !== 4'hF) begin
      fails++;
      $display("FAIL simul_ticks got %h exp f", press_tick);
    end
    step(1);
    tests++;
    if (count !== 16'h1111 || db !== 4'hF) begin
      fails++;
      $display("FAIL simul_count got %h db=%h exp 1111 f", count, db);
    end
    btn = 4'h0;
    step(13);
  endtask

  task automatic test_reset_mid_press();
    clear_acc();
    btn[0] = 1'b1;
    step(5);
    reset_n = 1'b0;
    #1;
    tests++;
    if ({db, count, press_tick, release_tick, rpt_tick} !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset got %h exp 0",
               {db, count, press_tick, release_tick, rpt_tick});
    end
    btn[0] = 1'b0;
    step(2);
    reset_n = 1'b1;
    clear_acc();
    step(20);
    tests++;
    if (press_n[0] != 0 || db !== 4'h0 || count !== 16'h0) begin
      fails++;
      $display("FAIL mid_reset_after got p=%0d db=%h c=%h exp 0 0 0",
               press_n[0], db, count);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    btn     = 4'h0;
    rpt_en  = 1'b0;
    clr     = 1'b0;
    db_prev = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_no_repeat();
    test_wrap_clr();
    test_simultaneous();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
